pf_load_arbiter: RTL and testbench

//  Merges the CPU load port and the prefetch-unit port onto one dcache load port (dcache_req_i_t/_o_t).

---
 rtl/wt_cache_pkg.sv | 33 +++
 rtl/pf_load_arbiter_if.sv | 20 ++
 rtl/pf_load_arbiter_owner_fifo.sv | 55 +++++
 rtl/pf_load_arbiter.sv | 124 ++++++++++++
 tb/tb_pf_load_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wt_cache_pkg.sv
// Shared dcache port types and the owner tag used by the prefetch/CPU load arbiter.
package wt_cache_pkg;

  localparam int unsigned IndexWidth = 12;
  localparam int unsigned TagWidth   = 20;
  localparam int unsigned DataWidth  = 64;

  typedef struct packed {
    logic [IndexWidth-1:0]  address_index;
    logic [TagWidth-1:0]    address_tag;
    logic [DataWidth-1:0]   data_wdata;
    logic                   data_req;
    logic                   data_we;
    logic [DataWidth/8-1:0] data_be;
    logic [1:0]             data_size;
    logic                   kill_req;
    logic                   tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                 data_gnt;
    logic                 data_rvalid;
    logic [DataWidth-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_PF} pf_owner_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pf_load_arbiter_if.sv
// Push/pop/status bundle between the arbiter (master) and its owner FIFO (slave).
interface pf_load_arbiter_if #(
  parameter int unsigned Depth = 4
) ();
  import wt_cache_pkg::*;

  localparam int unsigned CntW = cnt_width(Depth);

  logic            push;
  pf_owner_e       push_owner;
  logic            pop;
  pf_owner_e       head_owner;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;

  modport master (output push, push_owner, pop, input head_owner, full, empty, count);
  modport slave  (input push, push_owner, pop, output head_owner, full, empty, count);

endinterface

// File: rtl/pf_load_arbiter_owner_fifo.sv
// In-order FIFO of request owners; head_owner reads OWN_NONE while empty.
module pf_owner_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pf_load_arbiter_if.slave    fifo
);

  localparam int unsigned CntW = cnt_width(Depth);
  localparam int unsigned PtrW = $clog2(Depth);

  pf_owner_e       r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign fifo.full       = (r_count == CntW'(Depth));
  assign fifo.empty      = (r_count == '0);
  assign fifo.count      = r_count;
  assign fifo.head_owner = fifo.empty ? OWN_NONE : r_mem[r_rd_ptr];

  assign w_push = fifo.push && !fifo.full;
  assign w_pop  = fifo.pop && !fifo.empty;

  // NOTE: storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= fifo.push_owner;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pf_load_arbiter.sv
// Merges CPU and prefetch load ports onto one dcache read port, CPU first.
// Optional perf counters (pf_issued_o / pf_preempt_o) exist when PF_ARB_PERF_CNT_EN is defined.
module pf_load_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t cpu_req_i,
  output dcache_req_o_t cpu_rsp_o,
  input  dcache_req_i_t pf_req_i,
  output dcache_req_o_t pf_rsp_o,
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_rsp_i
`ifdef PF_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   pf_issued_o,
  output logic [31:0]   pf_preempt_o
`endif
);

  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  pf_load_arbiter_if #(.Depth(MaxOutstanding)) fifo_if ();

  pf_owner_e     w_sel;
  logic          w_sel_ok;
  logic          w_cpu_ok;
  logic          w_pf_ok;
  logic          w_grant;
  dcache_req_i_t w_idx_req;
  dcache_req_i_t w_tag_req;
  pf_owner_e     r_tag_owner;

  pf_owner_fifo #(.Depth(MaxOutstanding)) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .fifo   (fifo_if.slave)
  );

  // The last FIFO slot is held back so a CPU load can always issue.
  assign w_cpu_ok = (fifo_if.count < CntW'(MaxOutstanding));
  assign w_pf_ok  = (fifo_if.count < CntW'(MaxOutstanding - 1));

  // NOTE: combinational blocks use blocking assignments and default every output first.
  always_comb begin
    w_sel     = OWN_NONE;
    w_sel_ok  = 1'b0;
    w_idx_req = '0;
    w_tag_req = '0;
    if (cpu_req_i.data_req) begin
      w_sel     = OWN_CPU;
      w_sel_ok  = w_cpu_ok;
      w_idx_req = cpu_req_i;
    end else if (pf_req_i.data_req && w_pf_ok) begin
      w_sel     = OWN_PF;
      w_sel_ok  = 1'b1;
      w_idx_req = pf_req_i;
    end
    // Tag phase follows whoever was granted last cycle, not the current index owner.
    case (r_tag_owner)
      OWN_CPU: w_tag_req = cpu_req_i;
      OWN_PF:  w_tag_req = pf_req_i;
      default: w_tag_req = '0;
    endcase

    cache_req_o               = '0;
    cache_req_o.address_index = w_idx_req.address_index;
    cache_req_o.data_wdata    = w_idx_req.data_wdata;
    cache_req_o.data_we       = w_idx_req.data_we;
    cache_req_o.data_be       = w_idx_req.data_be;
    cache_req_o.data_size     = w_idx_req.data_size;
    cache_req_o.data_req      = (w_sel != OWN_NONE) && w_sel_ok;
    cache_req_o.address_tag   = w_tag_req.address_tag;
    cache_req_o.tag_valid     = w_tag_req.tag_valid;
    cache_req_o.kill_req      = w_tag_req.kill_req;
  end

  assign w_grant = cache_req_o.data_req && cache_rsp_i.data_gnt;

  assign fifo_if.push       = w_grant;
  assign fifo_if.push_owner = w_sel;
  assign fifo_if.pop        = cache_rsp_i.data_rvalid;

  assign cpu_rsp_o.data_gnt    = w_grant && (w_sel == OWN_CPU);
  assign pf_rsp_o.data_gnt     = w_grant && (w_sel == OWN_PF);
  assign cpu_rsp_o.data_rvalid = cache_rsp_i.data_rvalid && (fifo_if.head_owner == OWN_CPU);
  assign pf_rsp_o.data_rvalid  = cache_rsp_i.data_rvalid && (fifo_if.head_owner == OWN_PF);
  assign cpu_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
  assign pf_rsp_o.data_rdata   = cache_rsp_i.data_rdata;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_tag_owner <= OWN_NONE;
    else         r_tag_owner <= w_grant ? w_sel : OWN_NONE;
  end

`ifdef PF_ARB_PERF_CNT_EN
  logic [31:0] r_pf_issued;
  logic [31:0] r_pf_preempt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pf_issued  <= '0;
      r_pf_preempt <= '0;
    end else begin
      if (w_grant && (w_sel == OWN_PF) && (r_pf_issued != '1))
        r_pf_issued <= r_pf_issued + 1'b1;
      if (pf_req_i.data_req && cpu_req_i.data_req && (r_pf_preempt != '1))
        r_pf_preempt <= r_pf_preempt + 1'b1;
    end
  end

  assign pf_issued_o  = r_pf_issued;
  assign pf_preempt_o = r_pf_preempt;
`endif

  a_no_rvalid_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cache_rsp_i.data_rvalid |-> !fifo_if.empty);
  a_no_grant_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_grant |-> !fifo_if.full);

endmodule

// File: tb/tb_pf_load_arbiter.sv
// Directed bench for pf_load_arbiter: arbitration, tag-phase routing, in-order response return.
module tb_pf_load_arbiter;
  import wt_cache_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  dcache_req_i_t cpu_req;
  dcache_req_i_t pf_req;
  dcache_req_o_t cpu_rsp;
  dcache_req_o_t pf_rsp;
  dcache_req_i_t cache_req;
  dcache_req_o_t cache_rsp;
`ifdef PF_ARB_PERF_CNT_EN
  logic [31:0]   pf_issued;
  logic [31:0]   pf_preempt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pf_load_arbiter #(.MaxOutstanding(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_req_i   (cpu_req),
    .cpu_rsp_o   (cpu_rsp),
    .pf_req_i    (pf_req),
    .pf_rsp_o    (pf_rsp),
    .cache_req_o (cache_req),
    .cache_rsp_i (cache_rsp)
`ifdef PF_ARB_PERF_CNT_EN
    ,
    .pf_issued_o (pf_issued),
    .pf_preempt_o(pf_preempt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then clear all inputs.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cpu_req   = '0;
    pf_req    = '0;
    cache_rsp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic exp_pf_rv [4];
    exp_pf_rv = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst_ni    = 1'b0;
    cpu_req   = '0;
    pf_req    = '0;
    cache_rsp = '0;
    repeat (2) @(posedge clk_i);
    #1;
    cpu_req.tag_valid = 1'b1;
    #1;
    check("rst_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd0);
    check("rst_pf_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    check("rst_tag_valid", 64'(cache_req.tag_valid), 64'd0);
    check("rst_rvalid", 64'(cpu_rsp.data_rvalid | pf_rsp.data_rvalid), 64'd0);
    rst_ni = 1'b1;

    // CPU alone at index 0x10
    tick();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h010; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t1_index", 64'(cache_req.address_index), 64'h10);
    check("t1_data_req", 64'(cache_req.data_req), 64'd1);
    check("t1_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    check("t1_pf_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    tick();
    cpu_req.tag_valid = 1'b1; cpu_req.address_tag = 20'hABCDE;
    pf_req.tag_valid  = 1'b1; pf_req.address_tag  = 20'h11111;
    #1;
    check("t1_tag_valid", 64'(cache_req.tag_valid), 64'd1);
    check("t1_tag", 64'(cache_req.address_tag), 64'hABCDE);
    tick();
    cpu_req.tag_valid = 1'b1;
    cache_rsp.data_rvalid = 1'b1; cache_rsp.data_rdata = 64'h1234;
    #1;
    check("t1_tag_idle", 64'(cache_req.tag_valid), 64'd0);
    check("t1_cpu_rvalid", 64'(cpu_rsp.data_rvalid), 64'd1);
    check("t1_pf_rvalid", 64'(pf_rsp.data_rvalid), 64'd0);
    check("t1_pf_rdata", pf_rsp.data_rdata, 64'h1234);

    // CPU/PF collision, then PF, then CPU overlapping PF tag phase
    tick();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h020;
    pf_req.data_req  = 1'b1; pf_req.address_index  = 12'h030;
    cache_rsp.data_gnt = 1'b1;
    #1;
    check("t2_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    check("t2_pf_gnt", 64'(pf_rsp.data_gnt), 64'd0);
    check("t2_index", 64'(cache_req.address_index), 64'h20);
    tick();
    pf_req.data_req = 1'b1; pf_req.address_index = 12'h030; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t2_pf_gnt_retry", 64'(pf_rsp.data_gnt), 64'd1);
    check("t2_index_pf", 64'(cache_req.address_index), 64'h30);
    tick();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h040; cache_rsp.data_gnt = 1'b1;
    pf_req.tag_valid = 1'b1; pf_req.address_tag = 20'h22222;
    #1;
    check("t3_index_cpu", 64'(cache_req.address_index), 64'h40);
    check("t3_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    check("t3_tag_pf", 64'(cache_req.address_tag), 64'h22222);
    check("t3_tag_valid", 64'(cache_req.tag_valid), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    #1;
    check("t3_rv0_cpu", 64'(cpu_rsp.data_rvalid), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    #1;
    check("t3_rv1_pf", 64'(pf_rsp.data_rvalid), 64'd1);
    check("t3_rv1_cpu", 64'(cpu_rsp.data_rvalid), 64'd0);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    #1;
    check("t3_rv2_cpu", 64'(cpu_rsp.data_rvalid), 64'd1);

    // Fill the owner FIFO with responses withheld
    for (int i = 0; i < 3; i++) begin
      tick();
      pf_req.data_req = 1'b1; cache_rsp.data_gnt = 1'b1;
      #1;
      check($sformatf("t4_pf_gnt%0d", i), 64'(pf_rsp.data_gnt), 64'd1);
    end
    tick();
    pf_req.data_req = 1'b1; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t4_pf_blocked", 64'(pf_rsp.data_gnt), 64'd0);
    check("t4_pf_blocked_req", 64'(cache_req.data_req), 64'd0);
    tick();
    cpu_req.data_req = 1'b1; pf_req.data_req = 1'b1; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t4_cpu_last_slot", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_req.data_req = 1'b1; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t4_cpu_blocked", 64'(cpu_rsp.data_gnt), 64'd0);
    check("t4_cpu_blocked_req", 64'(cache_req.data_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cache_rsp.data_rvalid = 1'b1;
      #1;
      check($sformatf("t4_drain_pf%0d", i), 64'(pf_rsp.data_rvalid), 64'(exp_pf_rv[i]));
      check($sformatf("t4_drain_cpu%0d", i), 64'(cpu_rsp.data_rvalid), 64'(!exp_pf_rv[i]));
    end

    // CPU kill in tag phase while PF issues its index
    tick();
    cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h050; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t5_cpu_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
    tick();
    cpu_req.kill_req = 1'b1; cpu_req.tag_valid = 1'b1;
    pf_req.data_req = 1'b1; pf_req.address_index = 12'h060; cache_rsp.data_gnt = 1'b1;
    #1;
    check("t5_kill", 64'(cache_req.kill_req), 64'd1);
    check("t5_pf_gnt", 64'(pf_rsp.data_gnt), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    #1;
    check("t5_killed_rv_cpu", 64'(cpu_rsp.data_rvalid), 64'd1);
    tick();
    cache_rsp.data_rvalid = 1'b1;
    #1;
    check("t5_rv_pf", 64'(pf_rsp.data_rvalid), 64'd1);
    check("t5_rv_cpu", 64'(cpu_rsp.data_rvalid), 64'd0);

    // Reset with a grant pending in the tag register
    tick();
    cpu_req.data_req = 1'b1; cache_rsp.data_gnt = 1'b1;
    tick();
    cpu_req.tag_valid = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_tag_valid", 64'(cache_req.tag_valid), 64'd0);
    rst_ni = 1'b1;

`ifdef PF_ARB_PERF_CNT_EN
    tick();
    #1;
    check("perf_rst_issued", 64'(pf_issued), 64'd0);
    check("perf_rst_preempt", 64'(pf_preempt), 64'd0);
    for (int c = 0; c < 7; c++) begin
      tick();
      pf_req.data_req       = 1'b1;
      cpu_req.data_req      = (c == 2 || c == 3);
      cache_rsp.data_gnt    = 1'b1;
      cache_rsp.data_rvalid = (c != 0);
    end
    tick();
    cache_rsp.data_rvalid = 1'b1;
    tick();
    #1;
    check("perf_issued", 64'(pf_issued), 64'd5);
    check("perf_preempt", 64'(pf_preempt), 64'd2);
    rst_ni = 1'b0;
    #1;
    check("perf_mid_rst_issued", 64'(pf_issued), 64'd0);
    check("perf_mid_rst_preempt", 64'(pf_preempt), 64'd0);
    rst_ni = 1'b1;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
